// File: rtl/vga_timing_pkg.sv
// Shared 1024x768@60 timing constants and small helpers for the VGA video path.
// Imported by the timing generator and by the colour generator.
package vga_timing_pkg;

    localparam int unsigned CountWidth = 11;
    typedef logic [CountWidth-1:0] count_t;

    localparam int unsigned HActive     = 1024;
    localparam int unsigned HFrontPorch = 24;
    localparam int unsigned HSyncWidth  = 136;
    localparam int unsigned HBackPorch  = 160;

    localparam int unsigned VActive     = 768;
    localparam int unsigned VFrontPorch = 3;
    localparam int unsigned VSyncWidth  = 6;
    localparam int unsigned VBackPorch  = 29;

    localparam int unsigned HTotal = HActive + HFrontPorch + HSyncWidth + HBackPorch;
    localparam int unsigned VTotal = VActive + VFrontPorch + VSyncWidth + VBackPorch;

    // Flags describing the position an axis counter will hold after the current edge.
    typedef struct packed {
        logic active;
        logic sync;
        logic wrap;
    } axis_flags_t;

    function automatic logic sync_level(input logic in_sync, input logic polarity);
        return in_sync ? polarity : ~polarity;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping position counter plus look-ahead active/sync flags and
// a wrap strobe, so the parent can register its outputs aligned with the count.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned TOTAL      = HTotal,
    parameter int unsigned ACTIVE     = HActive,
    parameter int unsigned SYNC_START = HActive + HFrontPorch,
    parameter int unsigned SYNC_WIDTH = HSyncWidth
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        step,
    output count_t      count,
    output axis_flags_t nxt
);

    localparam count_t Last      = count_t'(TOTAL - 1);
    localparam count_t ActiveEnd = count_t'(ACTIVE);
    localparam count_t SyncStart = count_t'(SYNC_START);
    localparam count_t SyncEnd   = count_t'(SYNC_START + SYNC_WIDTH);

    count_t count_q;
    count_t count_d;
    logic   at_last;

    always_comb begin
        // >= keeps any out-of-range value from escaping the legal cycle.
        at_last = (count_q >= Last);
        count_d = count_q;
        if (step) begin
            count_d = at_last ? '0 : count_q + count_t'(1);
        end
        nxt        = '0;
        nxt.wrap   = step & at_last;
        nxt.active = (count_d < ActiveEnd);
        nxt.sync   = (count_d >= SyncStart) && (count_d < SyncEnd);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= Last;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters with registered, pixel-aligned
// active, sync and start-of-line/frame strobes, advancing only when en is high.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = HActive,
    parameter int unsigned H_FP     = HFrontPorch,
    parameter int unsigned H_SYNC   = HSyncWidth,
    parameter int unsigned H_BP     = HBackPorch,
    parameter int unsigned V_ACTIVE = VActive,
    parameter int unsigned V_FP     = VFrontPorch,
    parameter int unsigned V_SYNC   = VSyncWidth,
    parameter int unsigned V_BP     = VBackPorch,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic [10:0] count_h,
    output logic [10:0] count_v,
    output logic        EA,
    output logic        hsync,
    output logic        vsync,
    output logic        line_start,
    output logic        frame_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    count_t      h_count;
    count_t      v_count;
    axis_flags_t h_nxt;
    axis_flags_t v_nxt;

    logic ea_q;
    logic hsync_q;
    logic vsync_q;
    logic line_start_q;
    logic frame_start_q;

    vga_axis_counter #(
        .TOTAL      (H_TOTAL),
        .ACTIVE     (H_ACTIVE),
        .SYNC_START (H_ACTIVE + H_FP),
        .SYNC_WIDTH (H_SYNC)
    ) u_h_axis (
        .clk   (clk),
        .rst_n (rst_n),
        .step  (en),
        .count (h_count),
        .nxt   (h_nxt)
    );

    // The line counter steps once per horizontal wrap, which already implies en.
    vga_axis_counter #(
        .TOTAL      (V_TOTAL),
        .ACTIVE     (V_ACTIVE),
        .SYNC_START (V_ACTIVE + V_FP),
        .SYNC_WIDTH (V_SYNC)
    ) u_v_axis (
        .clk   (clk),
        .rst_n (rst_n),
        .step  (h_nxt.wrap),
        .count (v_count),
        .nxt   (v_nxt)
    );

    // Outputs are registered from the look-ahead flags so they describe the same
    // pixel as the counters, with no extra latency.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ea_q          <= 1'b0;
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            ea_q          <= h_nxt.active & v_nxt.active;
            hsync_q       <= sync_level(h_nxt.sync, HS_POL);
            vsync_q       <= sync_level(v_nxt.sync, VS_POL);
            line_start_q  <= h_nxt.wrap;
            frame_start_q <= v_nxt.wrap;
        end
    end

    assign count_h     = h_count;
    assign count_v     = v_count;
    assign EA          = ea_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a default-timing instance and a small,
// positive-polarity instance checked cycle by cycle against a reference model.
module tb_vga_timing_gen;

    typedef struct packed {
        logic [10:0] h;
        logic [10:0] v;
        logic        ea;
        logic        hs;
        logic        vs;
        logic        ls;
        logic        fs;
    } obs_t;

    typedef struct {
        int ha, hfp, hsw, hbp;
        int va, vfp, vsw, vbp;
        bit hp, vp;
    } cfg_t;

    logic clk = 1'b0;
    logic rst_n;
    logic en;

    logic [10:0] a_h, a_v, b_h, b_v;
    logic a_ea, a_hs, a_vs, a_ls, a_fs;
    logic b_ea, b_hs, b_vs, b_ls, b_fs;

    always #5 clk = ~clk;

    vga_timing_gen u_dut_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .count_h     (a_h),
        .count_v     (a_v),
        .EA          (a_ea),
        .hsync       (a_hs),
        .vsync       (a_vs),
        .line_start  (a_ls),
        .frame_start (a_fs)
    );

    vga_timing_gen #(
        .H_ACTIVE (16),
        .H_FP     (4),
        .H_SYNC   (6),
        .H_BP     (6),
        .V_ACTIVE (10),
        .V_FP     (2),
        .V_SYNC   (3),
        .V_BP     (3),
        .HS_POL   (1'b1),
        .VS_POL   (1'b1)
    ) u_dut_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .count_h     (b_h),
        .count_v     (b_v),
        .EA          (b_ea),
        .hsync       (b_hs),
        .vsync       (b_vs),
        .line_start  (b_ls),
        .frame_start (b_fs)
    );

    cfg_t cfg_a = '{ha: 1024, hfp: 24, hsw: 136, hbp: 160,
                    va: 768, vfp: 3, vsw: 6, vbp: 29, hp: 1'b0, vp: 1'b0};
    cfg_t cfg_b = '{ha: 16, hfp: 4, hsw: 6, hbp: 6,
                    va: 10, vfp: 2, vsw: 3, vbp: 3, hp: 1'b1, vp: 1'b1};

    int mh_a = 0, mv_a = 0, mh_b = 0, mv_b = 0;
    obs_t q_a[$];
    obs_t q_b[$];
    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    function automatic obs_t model(input cfg_t c, input bit r, input bit e,
                                   inout int h, inout int v);
        int   ht;
        int   vt;
        int   hss;
        int   vss;
        obs_t o;
        ht   = c.ha + c.hfp + c.hsw + c.hbp;
        vt   = c.va + c.vfp + c.vsw + c.vbp;
        hss  = c.ha + c.hfp;
        vss  = c.va + c.vfp;
        o.ls = 1'b0;
        o.fs = 1'b0;
        if (!r) begin
            h = ht - 1;
            v = vt - 1;
        end else if (e) begin
            if (h == ht - 1) begin
                h    = 0;
                o.ls = 1'b1;
                if (v == vt - 1) begin
                    v    = 0;
                    o.fs = 1'b1;
                end else begin
                    v = v + 1;
                end
            end else begin
                h = h + 1;
            end
        end
        o.h  = 11'(h);
        o.v  = 11'(v);
        o.ea = (h < c.ha) && (v < c.va);
        o.hs = (h >= hss && h < hss + c.hsw) ? c.hp : !c.hp;
        o.vs = (v >= vss && v < vss + c.vsw) ? c.vp : !c.vp;
        return o;
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("h=%0d v=%0d ea=%b hs=%b vs=%b ls=%b fs=%b",
                         o.h, o.v, o.ea, o.hs, o.vs, o.ls, o.fs);
    endfunction

    task automatic cmp(input string tag, input obs_t obs, input obs_t exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s cycle %0d: observed %s, expected %s", tag, cyc, fmt(obs), fmt(exp));
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s cycle %0d: observed %0d, expected %0d", tag, cyc, obs, exp);
        end
    endtask

    // Drive one edge, push the model's prediction, then pop and compare after the edge.
    task automatic tick(input bit r, input bit e);
        obs_t xa, xb, oa, ob;
        rst_n = r;
        en    = e;
        xa = model(cfg_a, r, e, mh_a, mv_a);
        xb = model(cfg_b, r, e, mh_b, mv_b);
        q_a.push_back(xa);
        q_b.push_back(xb);
        @(posedge clk);
        #1;
        cyc++;
        oa = {a_h, a_v, a_ea, a_hs, a_vs, a_ls, a_fs};
        ob = {b_h, b_v, b_ea, b_hs, b_vs, b_ls, b_fs};
        cmp("dut_a", oa, q_a.pop_front());
        cmp("dut_b", ob, q_b.pop_front());
    endtask

    initial begin
        int last_ls;
        int last_fs;
        int vs_cnt;
        int guard;
        logic [10:0] prev_bv;

        rst_n = 1'b0;
        en    = 1'b0;

        // Reset state, with en high to show reset wins.
        repeat (3) tick(1'b0, 1'b1);
        check("rst count_h", a_h, 1343);
        check("rst count_v", a_v, 805);
        check("rst hsync_a", a_hs, 1);
        check("rst vsync_a", a_vs, 1);
        check("rst hsync_b", b_hs, 0);

        // First enabled edge loads (0,0) with both strobes.
        tick(1'b1, 1'b1);
        check("first count_h", a_h, 0);
        check("first count_v", a_v, 0);
        check("first EA", a_ea, 1);
        check("first frame_start", a_fs, 1);
        check("first line_start", a_ls, 1);
        tick(1'b1, 1'b1);
        check("second count_h", a_h, 1);
        check("second line_start", a_ls, 0);
        check("second frame_start", a_fs, 0);

        // en pattern 1,0,1,0,1 after reset: 0,0,1,1,2.
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b0);
        check("en0 strobe", a_ls, 0);
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b1);
        check("en pattern count_h", a_h, 2);

        // Continuous run across several lines.
        last_ls = -1;
        for (int i = 0; i < 3 * 1344; i++) begin
            tick(1'b1, 1'b1);
            if (a_ls === 1'b1) begin
                if (last_ls >= 0) check("line_start period", cyc - last_ls, 1344);
                last_ls = cyc;
            end
            if (a_v == 11'd0 && a_h == 11'd1023) check("EA last active", a_ea, 1);
            if (a_h == 11'd1024) check("EA falls", a_ea, 0);
            if (a_h == 11'd1047) check("hsync before", a_hs, 1);
            if (a_h == 11'd1048) check("hsync start", a_hs, 0);
            if (a_h == 11'd1183) check("hsync end", a_hs, 0);
            if (a_h == 11'd1184) check("hsync after", a_hs, 1);
        end

        // Irregular enable: no skipped or repeated positions.
        repeat (600) tick(1'b1, 1'($urandom_range(0, 1)));

        // Reset in the middle of a frame.
        tick(1'b0, 1'b0);
        guard = 0;
        while (!(mh_a == 500 && mv_a == 1) && guard < 4000) begin
            tick(1'b1, 1'b1);
            guard++;
        end
        check("seek mid-frame", a_h, 500);
        tick(1'b0, 1'b1);
        check("midrst count_h", a_h, 1343);
        check("midrst count_v", a_v, 805);
        check("midrst EA", a_ea, 0);
        check("midrst hsync", a_hs, 1);
        check("midrst vsync", a_vs, 1);
        tick(1'b1, 1'b1);
        check("restart frame_start", a_fs, 1);

        // Whole frames on the small instance: period, vsync length, v wrap.
        tick(1'b0, 1'b1);
        last_fs = -1;
        vs_cnt  = 0;
        prev_bv = b_v;
        for (int i = 0; i < 1300; i++) begin
            tick(1'b1, 1'b1);
            if (b_fs === 1'b1) begin
                if (last_fs >= 0) begin
                    check("frame_start period", cyc - last_fs, 576);
                    check("vsync cycles per frame", vs_cnt, 96);
                    check("count_v wrap from", prev_bv, 17);
                end
                last_fs = cyc;
                vs_cnt  = 0;
            end
            if (b_vs === 1'b1) vs_cnt++;
            prev_bv = b_v;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
